// File: rtl/stick_pot_pkg.sv
// ---------------------------------------------------------------------------
// stick_pot_pkg
// Shared types and helpers for the Red Baron joystick-to-pot shaper.
//   axis_mode_t  : per-axis source of the pot value (CENTER, DIGITAL, ANALOG)
//   POT_CENTER   : resting pot value, the middle of the 0..255 range
//   sat_step     : move a pot value up or down by a step, pinned at 0/255
//   center_step  : move a pot value toward POT_CENTER, never crossing it
// ---------------------------------------------------------------------------
package stick_pot_pkg;

  typedef enum logic [1:0] {
    CENTER  = 2'd0,
    DIGITAL = 2'd1,
    ANALOG  = 2'd2
  } axis_mode_t;

  localparam logic [7:0] POT_CENTER = 8'd128;

  // A 9-bit intermediate exposes the carry/borrow, so an overflow past
  // 255 or an underflow below 0 pins the result instead of wrapping.
  function automatic logic [7:0] sat_step(input logic [7:0] val,
                                          input logic [7:0] step,
                                          input logic       up);
    logic [8:0] sum;
    logic [7:0] result;
    if (up) begin
      sum    = {1'b0, val} + {1'b0, step};
      result = sum[8] ? 8'hFF : sum[7:0];
    end else begin
      sum    = {1'b0, val} - {1'b0, step};
      result = sum[8] ? 8'h00 : sum[7:0];
    end
    return result;
  endfunction

  // Steps are at most 127, so moving from either side of 128 can never
  // wrap; all that remains is to stop exactly on the centre value.
  function automatic logic [7:0] center_step(input logic [7:0] val,
                                             input logic [7:0] step);
    logic [7:0] moved;
    logic [7:0] result;
    result = POT_CENTER;
    if (val > POT_CENTER) begin
      moved  = sat_step(val, step, 1'b0);
      result = (moved < POT_CENTER) ? POT_CENTER : moved;
    end else if (val < POT_CENTER) begin
      moved  = sat_step(val, step, 1'b1);
      result = (moved > POT_CENTER) ? POT_CENTER : moved;
    end
    return result;
  endfunction

endpackage

// File: rtl/stick_pot_shaper_if.sv
// ---------------------------------------------------------------------------
// stick_pot_shaper_if
// Bundles the joystick inputs and pot outputs of stick_pot_shaper.
//   enable     : shaping active; low forces both pots to centre
//   joy_dir    : {up, down, left, right} d-pad bits
//   joya       : analog stick, [7:0] signed X, [15:8] signed Y
//   audiosel   : pot select from the game, 1 = X, 0 = Y
//   pot_x      : shaped roll pot value
//   pot_y      : shaped pitch pot value
//   pot_out    : audiosel ? pot_x : pot_y
//   src_analog : {Y in ANALOG, X in ANALOG}
// The slave modport is the shaper's view, the master modport the driver's.
// ---------------------------------------------------------------------------
interface stick_pot_shaper_if;

  logic        enable;
  logic [3:0]  joy_dir;
  logic [15:0] joya;
  logic        audiosel;
  logic [7:0]  pot_x;
  logic [7:0]  pot_y;
  logic [7:0]  pot_out;
  logic [1:0]  src_analog;

  modport slave (
    input  enable, joy_dir, joya, audiosel,
    output pot_x, pot_y, pot_out, src_analog
  );

  modport master (
    output enable, joy_dir, joya, audiosel,
    input  pot_x, pot_y, pot_out, src_analog
  );

endinterface

// File: rtl/stick_axis_ramp.sv
// ---------------------------------------------------------------------------
// stick_axis_ramp
// One pot axis: chooses between analog stick, d-pad ramping and
// self-centering, and holds the resulting 8-bit pot value.
//   clk_i     : system clock
//   reset     : asynchronous active-high reset
//   enable_i  : shaping active; low forces CENTER and the centre value
//   tick_i    : one-cycle ramp tick
//   neg_i     : d-pad direction toward 0
//   pos_i     : d-pad direction toward 255
//   analog_i  : signed analog stick byte for this axis
//   pot_o     : registered pot value
//   analog_o  : axis currently in ANALOG mode
// ---------------------------------------------------------------------------
module stick_axis_ramp
  import stick_pot_pkg::*;
#(
  parameter int RAMP_STEP   = 4,
  parameter int RETURN_STEP = 8,
  parameter int DEADZONE    = 12
) (
  input  logic       clk_i,
  input  logic       reset,
  input  logic       enable_i,
  input  logic       tick_i,
  input  logic       neg_i,
  input  logic       pos_i,
  input  logic [7:0] analog_i,
  output logic [7:0] pot_o,
  output logic       analog_o
);

  axis_mode_t mode_q, mode_d;
  logic [7:0] pot_q, pot_d;
  logic [8:0] magnitude;
  logic       analogActive;
  logic       digitalActive;

  // Magnitude is 9 bits wide so that -128 comes out as +128 rather
  // than folding back onto itself.
  assign magnitude     = analog_i[7] ? (9'd256 - {1'b0, analog_i})
                                     : {1'b0, analog_i};
  assign analogActive  = (magnitude > 9'(DEADZONE));
  // Opposing directions cancel, so only a single held direction ramps.
  assign digitalActive = neg_i ^ pos_i;

  // Mode selection: analog beats d-pad, and with neither the axis
  // drifts back to centre. Disabling overrides everything.
  always_comb begin
    mode_d = CENTER;
    if (enable_i) begin
      if (analogActive) begin
        mode_d = ANALOG;
      end else if (digitalActive) begin
        mode_d = DIGITAL;
      end
    end
  end

  // Value update follows the mode chosen this cycle, so an analog sample
  // shows up on the pot one clock later and leaving ANALOG ramps from
  // whatever value the stick last produced.
  always_comb begin
    pot_d = pot_q;
    if (!enable_i) begin
      pot_d = POT_CENTER;
    end else begin
      case (mode_d)
        ANALOG: begin
          pot_d = analog_i ^ 8'h80;
        end
        DIGITAL: begin
          if (tick_i) begin
            pot_d = sat_step(pot_q, 8'(RAMP_STEP), pos_i);
          end
        end
        default: begin
          if (tick_i) begin
            pot_d = center_step(pot_q, 8'(RETURN_STEP));
          end
        end
      endcase
    end
  end

  // Mode and pot registers; reset drops straight to centre.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      mode_q <= CENTER;
      pot_q  <= POT_CENTER;
    end else begin
      mode_q <= mode_d;
      pot_q  <= pot_d;
    end
  end

  assign pot_o    = pot_q;
  assign analog_o = (mode_q == ANALOG);

endmodule

// File: rtl/stick_pot_shaper.sv
// ---------------------------------------------------------------------------
// stick_pot_shaper
// Turns MiSTer d-pad and analog stick input into the pitch/roll pot bytes
// read by the Red Baron POKEY pot scan.
//   clk_i  : system clock (50 MHz domain)
//   reset  : asynchronous active-high reset
//   bus    : stick_pot_shaper_if slave (joystick in, pot values out)
// Parameters: TICK_DIV clocks per ramp tick, RAMP_STEP / RETURN_STEP pot
// units per tick for d-pad ramping / self-centering, DEADZONE analog idle
// threshold.
// ---------------------------------------------------------------------------
module stick_pot_shaper
  import stick_pot_pkg::*;
#(
  parameter int TICK_DIV    = 50000,
  parameter int RAMP_STEP   = 4,
  parameter int RETURN_STEP = 8,
  parameter int DEADZONE    = 12
) (
  input logic                 clk_i,
  input logic                 reset,
  stick_pot_shaper_if.slave   bus
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;
  logic          analogX;
  logic          analogY;

  // Free-running ramp timebase, independent of enable so both axes
  // always share the same tick phase.
  assign tick  = (cnt_q == TICK_LAST);
  assign cnt_d = tick ? '0 : cnt_q + CW'(1);

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Roll axis: left pulls toward 0, right toward 255.
  stick_axis_ramp #(
    .RAMP_STEP   (RAMP_STEP),
    .RETURN_STEP (RETURN_STEP),
    .DEADZONE    (DEADZONE)
  ) u_axis_x (
    .clk_i    (clk_i),
    .reset    (reset),
    .enable_i (bus.enable),
    .tick_i   (tick),
    .neg_i    (bus.joy_dir[1]),
    .pos_i    (bus.joy_dir[0]),
    .analog_i (bus.joya[7:0]),
    .pot_o    (bus.pot_x),
    .analog_o (analogX)
  );

  // Pitch axis: up pulls toward 0, down toward 255.
  stick_axis_ramp #(
    .RAMP_STEP   (RAMP_STEP),
    .RETURN_STEP (RETURN_STEP),
    .DEADZONE    (DEADZONE)
  ) u_axis_y (
    .clk_i    (clk_i),
    .reset    (reset),
    .enable_i (bus.enable),
    .tick_i   (tick),
    .neg_i    (bus.joy_dir[3]),
    .pos_i    (bus.joy_dir[2]),
    .analog_i (bus.joya[15:8]),
    .pot_o    (bus.pot_y),
    .analog_o (analogY)
  );

  assign bus.src_analog = {analogY, analogX};
  assign bus.pot_out    = bus.audiosel ? bus.pot_x : bus.pot_y;

endmodule
